// File: rtl/debug_ctrl_v2.sv
// Debug controller: Avalon-MM register file, halt/run/step FSM, PC breakpoints
// and per-stage pipeline enables for a core under debug.
module debug_ctrl_v2 #(
  parameter int N_STAGES = 4,
  parameter int NUM_BP   = 2,
  parameter int CNT_W    = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [3:0]          address,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         data_internal,
  output logic                debug,
  output logic [N_STAGES-1:0] enable_ext,
  output logic                enable_pc_ext,
  output logic                tx_flag,
  output logic [2:0]          mode,
  output logic [31:0]         address_bridged,
  output logic [31:0]         data_bridged,
  output logic                halted
);

  localparam int CTRL_W = 7 + NUM_BP;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_ADDR     = 4'd1;
  localparam logic [3:0] A_DATA     = 4'd2;
  localparam logic [3:0] A_STATUS   = 4'd3;
  localparam logic [3:0] A_STEP_DIV = 4'd4;
  localparam logic [3:0] A_STEP_CNT = 4'd5;
  localparam logic [3:0] A_READBACK = 4'd6;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       addr_q, data_q;
  logic [CNT_W-1:0]  step_div_q, presc_q;
  logic [15:0]       step_cnt_q;
  logic [31:0]       bp_addr_q [NUM_BP];
  logic              bp_hit_q;
  logic [2:0]        bp_idx_q;
  logic              tx_q;

  logic              wr_en, rd_en;
  logic              dbg_en, run, step_mode, bp_en;
  logic [2:0]        acc_mode;
  logic [NUM_BP-1:0] bp_mask;
  logic              bp_match, bp_fire, step_pulse, hw_run_clr, en_all;
  logic [2:0]        bp_sel;
  logic [31:0]       rd_mux;

  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;
  assign dbg_en    = ctrl_q[0];
  assign run       = ctrl_q[1];
  assign step_mode = ctrl_q[2];
  assign acc_mode  = ctrl_q[5:3];
  assign bp_en     = ctrl_q[6];
  assign bp_mask   = ctrl_q[CTRL_W-1:7];

  // Scan from the top down so the lowest matching comparator wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    bp_match = 1'b0;
    bp_sel   = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_mask[i] && (pc_in == bp_addr_q[i])) begin
        bp_match = 1'b1;
        bp_sel   = 3'(i);
      end
    end
  end

  assign bp_fire = dbg_en && run && bp_en && bp_match &&
                   ((state_q == S_RUN) || (state_q == S_STEP));

  // A breakpoint match suppresses the pulse so the core halts before it.
  assign step_pulse = (state_q == S_STEP) && dbg_en && run && !bp_fire &&
                      (step_cnt_q != 16'd0) && (presc_q == step_div_q);

  always_comb begin
    state_d    = state_q;
    hw_run_clr = 1'b0;
    if (!dbg_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_HALT;
        S_HALT: if (run) state_d = step_mode ? S_STEP : S_RUN;
        S_RUN: begin
          if (!run) begin
            state_d = S_HALT;
          end else if (bp_fire) begin
            state_d    = S_HALT;
            hw_run_clr = 1'b1;
          end
        end
        default: begin
          if (!run) begin
            state_d = S_HALT;
          end else if (bp_fire || (step_cnt_q == 16'd0) ||
                       (step_pulse && (step_cnt_q == 16'd1))) begin
            state_d    = S_HALT;
            hw_run_clr = 1'b1;
          end
        end
      endcase
    end
  end

  // A software CTRL write lands, but a same-cycle hardware run-clear still wins on bit 1.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en && (address == A_CTRL)) ctrl_d = writedata[CTRL_W-1:0];
    if (hw_run_clr) ctrl_d[1] = 1'b0;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      A_CTRL:     rd_mux = 32'(ctrl_q);
      A_ADDR:     rd_mux = addr_q;
      A_DATA:     rd_mux = data_q;
      A_STATUS:   rd_mux = {27'd0, bp_idx_q, bp_hit_q, (state_q == S_HALT)};
      A_STEP_DIV: rd_mux = 32'(step_div_q);
      A_STEP_CNT: rd_mux = {16'd0, step_cnt_q};
      A_READBACK: rd_mux = data_internal;
      default: begin
        for (int i = 0; i < NUM_BP; i++) begin
          if (address == 4'(8 + i)) rd_mux = bp_addr_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: sequential state uses non-blocking assignments only; the small breakpoint array is reset like any other register.
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      step_div_q <= '0;
      step_cnt_q <= '0;
      presc_q    <= '0;
      bp_hit_q   <= 1'b0;
      bp_idx_q   <= 3'd0;
      tx_q       <= 1'b0;
      readdata   <= '0;
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;

      if (wr_en && (address == A_ADDR))     addr_q     <= writedata;
      if (wr_en && (address == A_DATA))     data_q     <= writedata;
      if (wr_en && (address == A_STEP_DIV)) step_div_q <= CNT_W'(writedata);
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_en && (address == 4'(8 + i))) bp_addr_q[i] <= writedata;
      end

      if (wr_en && (address == A_STEP_CNT)) step_cnt_q <= writedata[15:0];
      else if (step_pulse)                  step_cnt_q <= step_cnt_q - 16'd1;

      // Held at 0 outside STEP, so every entry starts a fresh prescale period.
      if ((state_q != S_STEP) || step_pulse) presc_q <= '0;
      else                                   presc_q <= presc_q + CNT_W'(1);

      if (bp_fire) begin
        bp_hit_q <= 1'b1;
        bp_idx_q <= bp_sel;
      end else if (wr_en && (address == A_STATUS) && writedata[1]) begin
        bp_hit_q <= 1'b0;
        bp_idx_q <= 3'd0;
      end

      tx_q <= wr_en && (address == A_CTRL) && (state_q == S_HALT) && writedata[0] &&
              ((writedata[5:3] == 3'b001) || (writedata[5:3] == 3'b010) ||
               (writedata[5:3] == 3'b101));

      if (rd_en) readdata <= rd_mux;
    end
  end

  assign en_all          = (state_q == S_IDLE) || (state_q == S_RUN) || step_pulse;
  assign enable_ext      = {N_STAGES{en_all}};
  assign enable_pc_ext   = en_all;
  assign debug           = dbg_en;
  assign tx_flag         = tx_q;
  assign mode            = (state_q == S_HALT) ? acc_mode : 3'b000;
  assign halted          = (state_q == S_HALT);
  assign address_bridged = addr_q;
  assign data_bridged    = data_q;

endmodule

// File: tb/tb_debug_ctrl_v2.sv
// Directed bench for debug_ctrl_v2: register table plus hand-written
// halt/step/breakpoint/reset sequences, all expectations computed by hand.
module tb_debug_ctrl_v2;

  localparam int NS = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [3:0]    address = '0;
  logic [31:0]   writedata = '0, readdata;
  logic [31:0]   pc_in = '0, data_internal = 32'h5A5A_0F0F;
  logic          debug, enable_pc_ext, tx_flag, halted;
  logic [NS-1:0] enable_ext;
  logic [2:0]    mode;
  logic [31:0]   address_bridged, data_bridged;

  int n_tests = 0;
  int n_fail  = 0;

  debug_ctrl_v2 #(.N_STAGES(NS), .NUM_BP(2), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .pc_in(pc_in), .data_internal(data_internal), .debug(debug),
    .enable_ext(enable_ext), .enable_pc_ext(enable_pc_ext), .tx_flag(tx_flag),
    .mode(mode), .address_bridged(address_bridged), .data_bridged(data_bridged),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge CLK);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge CLK);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int pulses, first_k, second_k, bad, halt_k2;

    vecs[0]  = '{4'd0,  32'hFFFF_FFF8, 32'h0000_01F8};
    vecs[1]  = '{4'd1,  32'h1234_5678, 32'h1234_5678};
    vecs[2]  = '{4'd2,  32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[3]  = '{4'd4,  32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[4]  = '{4'd5,  32'hDEAD_BEEF, 32'h0000_BEEF};
    vecs[5]  = '{4'd3,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{4'd6,  32'h1111_1111, 32'h5A5A_0F0F};
    vecs[7]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{4'd8,  32'h0000_0100, 32'h0000_0100};
    vecs[9]  = '{4'd9,  32'h0000_0200, 32'h0000_0200};
    vecs[10] = '{4'd10, 32'h0000_FFFF, 32'h0000_0000};
    vecs[11] = '{4'd15, 32'h0000_FFFF, 32'h0000_0000};

    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Reset state
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_enables", 32'(enable_ext), 32'hF);
    check("rst_pc_en", 32'(enable_pc_ext), 32'h1);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_tx", 32'(tx_flag), 32'h0);
    check("rst_readdata", readdata, 32'h0);
    check("rst_debug", 32'(debug), 32'h0);

    // Register map table (dbg_en stays 0 throughout)
    for (int i = 0; i < 12; i++) begin
      write_reg(vecs[i].addr, vecs[i].wdata);
      read_reg(vecs[i].addr, rd);
      check($sformatf("reg_rw[%0d]", vecs[i].addr), rd, vecs[i].exp);
    end
    check("addr_bridged", address_bridged, 32'h1234_5678);
    check("data_bridged", data_bridged, 32'hCAFE_F00D);
    check("table_idle_en", 32'(enable_ext), 32'hF);

    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    check("rst2_readdata", readdata, 32'h0);

    // Enter and leave HALT
    write_reg(4'd0, 32'h1);
    check("debug_out", 32'(debug), 32'h1);
    @(negedge CLK);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_enables", 32'(enable_ext), 32'h0);
    write_reg(4'd0, 32'h0);
    @(negedge CLK);
    check("idle_halted", 32'(halted), 32'h0);
    check("idle_enables", 32'(enable_ext), 32'hF);

    // Access strobe in HALT
    write_reg(4'd0, 32'h1);
    @(negedge CLK);
    write_reg(4'd0, 32'h09);
    check("tx_pulse", 32'(tx_flag), 32'h1);
    check("tx_mode", 32'(mode), 32'h1);
    check("tx_enables", 32'(enable_ext), 32'h0);
    @(negedge CLK);
    check("tx_one_cycle", 32'(tx_flag), 32'h0);
    check("tx_mode_hold", 32'(mode), 32'h1);
    write_reg(4'd0, 32'h19);
    check("tx_acc011", 32'(tx_flag), 32'h0);
    check("mode_011", 32'(mode), 32'h3);

    // Two step pulses, STEP_DIV=3
    write_reg(4'd4, 32'd3);
    write_reg(4'd5, 32'd2);
    write_reg(4'd0, 32'h07);
    pulses = 0; first_k = 0; second_k = 0; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (enable_pc_ext !== enable_ext[0]) bad++;
      if (enable_ext == 4'hF) begin
        pulses++;
        if (pulses == 1) first_k = k;
        if (pulses == 2) second_k = k;
      end else if (enable_ext != 4'h0) begin
        bad++;
      end
    end
    check("step_pulses", 32'(pulses), 32'd2);
    check("step_first_k", 32'(first_k), 32'd4);
    check("step_gap", 32'(second_k - first_k), 32'd4);
    check("step_bad_en", 32'(bad), 32'd0);
    check("step_halted", 32'(halted), 32'h1);
    read_reg(4'd0, rd);
    check("step_ctrl", rd, 32'h05);
    read_reg(4'd5, rd);
    check("step_cnt_end", rd, 32'h0);

    // STEP with STEP_CNT=0
    write_reg(4'd0, 32'h07);
    pulses = 0; halt_k2 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (enable_ext != 4'h0) pulses++;
      if (k == 2) halt_k2 = int'(halted);
    end
    check("step0_pulses", 32'(pulses), 32'd0);
    check("step0_halt", 32'(halt_k2), 32'd1);
    read_reg(4'd0, rd);
    check("step0_ctrl", rd, 32'h05);

    // Breakpoint 1 in RUN
    write_reg(4'd9, 32'h100);
    write_reg(4'd0, 32'h1C3);
    @(negedge CLK);
    check("run_enables", 32'(enable_ext), 32'hF);
    check("run_halted", 32'(halted), 32'h0);
    pc_in = 32'h100;
    @(negedge CLK);
    check("bp_halted", 32'(halted), 32'h1);
    check("bp_enables", 32'(enable_ext), 32'h0);
    read_reg(4'd3, rd);
    check("bp_status", rd, 32'h7);
    read_reg(4'd0, rd);
    check("bp_ctrl", rd, 32'h1C1);
    pc_in = 32'h0;
    write_reg(4'd3, 32'h2);
    read_reg(4'd3, rd);
    check("bp_clear", rd, 32'h1);

    // Both comparators match: lowest index wins
    write_reg(4'd8, 32'h100);
    pc_in = 32'h100;
    write_reg(4'd0, 32'h1C3);
    repeat (2) @(negedge CLK);
    read_reg(4'd3, rd);
    check("bp_lowest", rd, 32'h3);
    pc_in = 32'h0;
    write_reg(4'd3, 32'h2);

    // Software CTRL write colliding with a breakpoint run-clear
    write_reg(4'd0, 32'h1C3);
    @(negedge CLK);
    pc_in = 32'h100;
    chipselect = 1'b1; write = 1'b1; address = 4'd0; writedata = 32'h1CB;
    @(negedge CLK);
    chipselect = 1'b0; write = 1'b0; pc_in = 32'h0;
    check("collide_halted", 32'(halted), 32'h1);
    read_reg(4'd0, rd);
    check("collide_ctrl", rd, 32'h1C9);

    // Reset in the middle of a STEP_DIV=5 step
    write_reg(4'd1, 32'hDEAD_0001);
    write_reg(4'd4, 32'd5);
    write_reg(4'd5, 32'd3);
    write_reg(4'd0, 32'h07);
    pulses = 0;
    repeat (3) begin
      @(negedge CLK);
      if (enable_ext != 4'h0) pulses++;
    end
    check("pre_rst_pulses", 32'(pulses), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_halted", 32'(halted), 32'h0);
    check("mid_rst_enables", 32'(enable_ext), 32'hF);
    check("mid_rst_mode", 32'(mode), 32'h0);
    check("mid_rst_tx", 32'(tx_flag), 32'h0);
    check("mid_rst_readdata", readdata, 32'h0);
    check("mid_rst_addr_br", address_bridged, 32'h0);
    RST = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge CLK);
      if ((enable_ext != 4'hF) || (halted != 1'b0)) bad++;
    end
    check("post_rst_idle", 32'(bad), 32'd0);
    read_reg(4'd0, rd);
    check("post_rst_ctrl", rd, 32'h0);
    read_reg(4'd4, rd);
    check("post_rst_div", rd, 32'h0);
    read_reg(4'd5, rd);
    check("post_rst_cnt", rd, 32'h0);
    read_reg(4'd8, rd);
    check("post_rst_bp0", rd, 32'h0);
    read_reg(4'd3, rd);
    check("post_rst_status", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
